// File: rtl/pa_core_lsu.sv
// Sequential load/store unit: valid/ready request in, aligned strobed bus beats out, one response pulse back.
// Define PA_CORE_LSU_MISALIGN_EN to split misaligned accesses into two beats; otherwise they return an error.
module pa_core_lsu #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      req_vld_i,
    output logic                      req_rdy_o,
    input  logic                      req_load_i,
    input  logic                      req_store_i,
    input  logic [1:0]                req_size_i,
    input  logic                      req_sign_i,
    input  logic [ADDR_WIDTH-1:0]     req_addr_i,
    input  logic [DATA_WIDTH-1:0]     req_wdata_i,
    output logic                      rsp_vld_o,
    output logic [DATA_WIDTH-1:0]     rsp_data_o,
    output logic                      rsp_err_o,
    output logic                      busy_o,
    output logic                      bus_req_o,
    output logic                      bus_we_o,
    output logic [ADDR_WIDTH-1:0]     bus_addr_o,
    output logic [DATA_WIDTH-1:0]     bus_wdata_o,
    output logic [DATA_WIDTH/8-1:0]   bus_strb_o,
    input  logic                      bus_gnt_i,
    input  logic                      bus_rvld_i,
    input  logic [DATA_WIDTH-1:0]     bus_rdata_i,
    input  logic                      bus_err_i
);

    localparam int NB = DATA_WIDTH / 8;
    localparam int OW = $clog2(NB);
    localparam int SW = $clog2(DATA_WIDTH) + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_REQ1, S_WAIT1, S_REQ2, S_WAIT2, S_RESP
    } state_e;

    state_e                state_q, state_d;
    logic                  load_q, load_d;
    logic [1:0]            size_q, size_d;
    logic                  sign_q, sign_d;
    logic [OW-1:0]         off_q, off_d;
`ifdef PA_CORE_LSU_MISALIGN_EN
    logic                  split_q, split_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [NB-1:0]         strb_hi_q, strb_hi_d;
    logic [DATA_WIDTH-1:0] wdata_hi_q, wdata_hi_d;
    logic [DATA_WIDTH-1:0] beat1_q, beat1_d;
    logic [SW-1:0]         sh_hi;
    logic [SW-1:0]         sh_hi_in;
`endif
    logic                  req_rdy_q, req_rdy_d;
    logic                  busy_q, busy_d;
    logic                  rsp_vld_q, rsp_vld_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  bus_req_q, bus_req_d;
    logic                  bus_we_q, bus_we_d;
    logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_WIDTH-1:0] bus_wdata_q, bus_wdata_d;
    logic [NB-1:0]         bus_strb_q, bus_strb_d;

    logic [2*NB-1:0]       mask_w;
    logic [OW-1:0]         off_in;
    logic [ADDR_WIDTH-1:0] addr_aligned;
    logic                  illegal_in;

    // Keep the low 8<<size bits of raw and fill the rest with the sign bit or zero.
    function automatic logic [DATA_WIDTH-1:0] extend_load(input logic [DATA_WIDTH-1:0] raw,
                                                          input logic [1:0] size,
                                                          input logic sign);
        logic [DATA_WIDTH-1:0] res;
        logic                  fill;
        int                    width;
        width = 8 << size;
        if (width > DATA_WIDTH) width = DATA_WIDTH;
        fill = 1'b0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (i == width - 1) fill = sign & raw[i];
        end
        res = raw;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (i >= width) res[i] = fill;
        end
        return res;
    endfunction

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d     = state_q;
        load_d      = load_q;
        size_d      = size_q;
        sign_d      = sign_q;
        off_d       = off_q;
`ifdef PA_CORE_LSU_MISALIGN_EN
        split_d     = split_q;
        addr_d      = addr_q;
        strb_hi_d   = strb_hi_q;
        wdata_hi_d  = wdata_hi_q;
        beat1_d     = beat1_q;
        sh_hi       = SW'(DATA_WIDTH) - SW'({off_q, 3'b000});
        sh_hi_in    = SW'(DATA_WIDTH) - SW'({req_addr_i[OW-1:0], 3'b000});
`endif
        rsp_vld_d   = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_strb_d  = bus_strb_q;

        mask_w = '0;
        for (int i = 0; i < 8; i++) begin
            if (i < (1 << req_size_i)) mask_w[i] = 1'b1;
        end
        off_in       = req_addr_i[OW-1:0];
        addr_aligned = {req_addr_i[ADDR_WIDTH-1:OW], {OW{1'b0}}};
        illegal_in   = (req_load_i == req_store_i) || (req_size_i == 2'd3 && DATA_WIDTH == 32);
`ifndef PA_CORE_LSU_MISALIGN_EN
        illegal_in   = illegal_in || (|(off_in & mask_w[OW:1]));
`endif

        case (state_q)
            S_IDLE: begin
                rsp_data_d = '0;
                rsp_err_d  = 1'b0;
                if (req_vld_i && req_rdy_q) begin
                    load_d = req_load_i;
                    size_d = req_size_i;
                    sign_d = req_sign_i;
                    off_d  = off_in;
`ifdef PA_CORE_LSU_MISALIGN_EN
                    addr_d     = addr_aligned;
                    strb_hi_d  = NB'((mask_w << off_in) >> NB);
                    split_d    = |strb_hi_d;
                    wdata_hi_d = req_wdata_i >> sh_hi_in;
`endif
                    if (illegal_in) begin
                        state_d   = S_RESP;
                        rsp_vld_d = 1'b1;
                        rsp_err_d = 1'b1;
                    end else begin
                        state_d     = S_REQ1;
                        bus_req_d   = 1'b1;
                        bus_we_d    = req_store_i;
                        bus_addr_d  = addr_aligned;
                        bus_strb_d  = NB'(mask_w << off_in);
                        bus_wdata_d = req_wdata_i << {off_in, 3'b000};
                    end
                end
            end
            S_REQ1, S_REQ2: begin
                // Bus outputs stay registered and untouched until the grant arrives.
                if (bus_gnt_i) begin
                    state_d     = (state_q == S_REQ1) ? S_WAIT1 : S_WAIT2;
                    bus_req_d   = 1'b0;
                    bus_we_d    = 1'b0;
                    bus_addr_d  = '0;
                    bus_strb_d  = '0;
                    bus_wdata_d = '0;
                end
            end
            S_WAIT1: begin
                if (bus_rvld_i) begin
                    if (bus_err_i) begin
                        state_d    = S_RESP;
                        rsp_vld_d  = 1'b1;
                        rsp_err_d  = 1'b1;
                        rsp_data_d = '0;
`ifdef PA_CORE_LSU_MISALIGN_EN
                    end else if (split_q) begin
                        beat1_d     = bus_rdata_i >> {off_q, 3'b000};
                        state_d     = S_REQ2;
                        bus_req_d   = 1'b1;
                        bus_we_d    = ~load_q;
                        bus_addr_d  = addr_q + ADDR_WIDTH'(NB);
                        bus_strb_d  = strb_hi_q;
                        bus_wdata_d = wdata_hi_q;
`endif
                    end else begin
                        state_d    = S_RESP;
                        rsp_vld_d  = 1'b1;
                        rsp_err_d  = 1'b0;
                        rsp_data_d = load_q ? extend_load(bus_rdata_i >> {off_q, 3'b000}, size_q, sign_q)
                                            : '0;
                    end
                end
            end
`ifdef PA_CORE_LSU_MISALIGN_EN
            S_WAIT2: begin
                if (bus_rvld_i) begin
                    state_d    = S_RESP;
                    rsp_vld_d  = 1'b1;
                    rsp_err_d  = bus_err_i;
                    rsp_data_d = (load_q && !bus_err_i)
                               ? extend_load(beat1_q | (bus_rdata_i << sh_hi), size_q, sign_q)
                               : '0;
                end
            end
`endif
            S_RESP: begin
                state_d    = S_IDLE;
                rsp_data_d = '0;
                rsp_err_d  = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase

        req_rdy_d = (state_d == S_IDLE);
        busy_d    = (state_d != S_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            load_q      <= 1'b0;
            size_q      <= '0;
            sign_q      <= 1'b0;
            off_q       <= '0;
`ifdef PA_CORE_LSU_MISALIGN_EN
            split_q     <= 1'b0;
            addr_q      <= '0;
            strb_hi_q   <= '0;
            wdata_hi_q  <= '0;
            beat1_q     <= '0;
`endif
            req_rdy_q   <= 1'b1;
            busy_q      <= 1'b0;
            rsp_vld_q   <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_strb_q  <= '0;
        end else begin
            state_q     <= state_d;
            load_q      <= load_d;
            size_q      <= size_d;
            sign_q      <= sign_d;
            off_q       <= off_d;
`ifdef PA_CORE_LSU_MISALIGN_EN
            split_q     <= split_d;
            addr_q      <= addr_d;
            strb_hi_q   <= strb_hi_d;
            wdata_hi_q  <= wdata_hi_d;
            beat1_q     <= beat1_d;
`endif
            req_rdy_q   <= req_rdy_d;
            busy_q      <= busy_d;
            rsp_vld_q   <= rsp_vld_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_strb_q  <= bus_strb_d;
        end
    end

    assign req_rdy_o   = req_rdy_q;
    assign busy_o      = busy_q;
    assign rsp_vld_o   = rsp_vld_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_err_o   = rsp_err_q;
    assign bus_req_o   = bus_req_q;
    assign bus_we_o    = bus_we_q;
    assign bus_addr_o  = bus_addr_q;
    assign bus_wdata_o = bus_wdata_q;
    assign bus_strb_o  = bus_strb_q;

endmodule

// File: tb/tb_pa_core_lsu.sv
// Self-checking bench for pa_core_lsu: directed steps plus random traffic against a byte-memory reference model.
// Follows PA_CORE_LSU_MISALIGN_EN when it is defined for the build.
module tb_pa_core_lsu;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int NB = DW / 8;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          req_vld_i, req_rdy_o, req_load_i, req_store_i, req_sign_i;
    logic [1:0]    req_size_i;
    logic [AW-1:0] req_addr_i;
    logic [DW-1:0] req_wdata_i;
    logic          rsp_vld_o, rsp_err_o, busy_o;
    logic [DW-1:0] rsp_data_o;
    logic          bus_req_o, bus_we_o, bus_gnt_i, bus_rvld_i, bus_err_i;
    logic [AW-1:0] bus_addr_o;
    logic [DW-1:0] bus_wdata_o, bus_rdata_i;
    logic [NB-1:0] bus_strb_o;

    always #5 clk = ~clk;

    pa_core_lsu #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_vld_i(req_vld_i), .req_rdy_o(req_rdy_o), .req_load_i(req_load_i),
        .req_store_i(req_store_i), .req_size_i(req_size_i), .req_sign_i(req_sign_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .rsp_vld_o(rsp_vld_o), .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o), .busy_o(busy_o),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_wdata_o(bus_wdata_o), .bus_strb_o(bus_strb_o), .bus_gnt_i(bus_gnt_i),
        .bus_rvld_i(bus_rvld_i), .bus_rdata_i(bus_rdata_i), .bus_err_i(bus_err_i)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Bus memory seen through the DUT, and the reference memory updated by the model.
    logic [7:0] bus_mem [0:1023];
    logic [7:0] ref_mem [0:1023];

    // Bus slave controls and per-transaction observations.
    int            gnt_delay = 0;
    int            rsp_delay = 0;
    bit            err_next = 0;
    int            beats;
    int            req_cycles;
    bit            hold_bad;
    logic [AW-1:0] b_addr  [2];
    logic [NB-1:0] b_strb  [2];
    logic [DW-1:0] b_wdata [2];
    logic          b_we    [2];

    initial begin
        bit            pend, waiting, pend_err;
        int            gnt_cnt, rsp_cnt, a;
        logic [DW-1:0] pend_data;
        logic [AW-1:0] h_addr;
        logic [NB-1:0] h_strb;
        logic [DW-1:0] h_wdata;
        logic          h_we;
        pend = 0; waiting = 0; pend_err = 0; gnt_cnt = 0; rsp_cnt = 0; pend_data = '0;
        h_addr = '0; h_strb = '0; h_wdata = '0; h_we = 0;
        bus_gnt_i = 0; bus_rvld_i = 0; bus_rdata_i = '0; bus_err_i = 0;
        forever begin
            @(posedge clk); #1;
            bus_gnt_i = 0; bus_rvld_i = 0; bus_err_i = 0; bus_rdata_i = '0;
            if (pend) begin
                if (rsp_cnt > 0) rsp_cnt--;
                else begin
                    bus_rvld_i = 1; bus_rdata_i = pend_data; bus_err_i = pend_err; pend = 0;
                end
            end else if (bus_req_o && !rst_i) begin
                if (!waiting) begin
                    waiting = 1; gnt_cnt = gnt_delay;
                    h_addr = bus_addr_o; h_strb = bus_strb_o; h_wdata = bus_wdata_o; h_we = bus_we_o;
                end else if (bus_addr_o !== h_addr || bus_strb_o !== h_strb ||
                             bus_wdata_o !== h_wdata || bus_we_o !== h_we) begin
                    hold_bad = 1;
                end
                req_cycles++;
                if (gnt_cnt > 0) gnt_cnt--;
                else begin
                    bus_gnt_i = 1; waiting = 0;
                    if (beats < 2) begin
                        b_addr[beats] = bus_addr_o; b_strb[beats] = bus_strb_o;
                        b_wdata[beats] = bus_wdata_o; b_we[beats] = bus_we_o;
                    end
                    beats++;
                    a = int'(bus_addr_o[9:0]);
                    for (int i = 0; i < NB; i++) begin
                        if (bus_we_o && bus_strb_o[i]) bus_mem[(a + i) & 1023] = bus_wdata_o[8*i +: 8];
                        pend_data[8*i +: 8] = bus_mem[(a + i) & 1023];
                    end
                    pend_err = err_next; err_next = 0; pend = 1; rsp_cnt = rsp_delay;
                end
            end
        end
    end

    // Reference model: byte-addressed little-endian memory, access rules applied directly.
    task automatic model(input bit ld, input bit st, input logic [1:0] sz, input bit sg,
                         input logic [AW-1:0] ad, input logic [DW-1:0] wd,
                         output logic [DW-1:0] e_data, output logic e_err, output int e_beats);
        int         n, off, a;
        bit         illegal;
        logic [63:0] v;
        n = 1 << sz;
        off = int'(ad) % NB;
        a = int'(ad[9:0]);
        illegal = (ld == st) || (sz == 2'd3);
`ifndef PA_CORE_LSU_MISALIGN_EN
        illegal = illegal || ((off % n) != 0);
`endif
        e_data = '0;
        if (illegal) begin
            e_err = 1; e_beats = 0;
        end else begin
            e_err = 0;
            e_beats = (off + n > NB) ? 2 : 1;
            if (st) begin
                for (int i = 0; i < n; i++) ref_mem[(a + i) & 1023] = wd[8*i +: 8];
            end else begin
                v = '0;
                for (int i = 0; i < n; i++) v = v | (64'(ref_mem[(a + i) & 1023]) << (8 * i));
                if (sg && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
                e_data = v[DW-1:0];
            end
        end
    endtask

    task automatic set_word(input int a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            bus_mem[a + i] = w[8*i +: 8];
            ref_mem[a + i] = w[8*i +: 8];
        end
    endtask

    task automatic do_req(input bit ld, input bit st, input logic [1:0] sz, input bit sg,
                          input logic [AW-1:0] ad, input logic [DW-1:0] wd,
                          output logic [DW-1:0] r_data, output logic r_err, output int lat,
                          output logic rdy_in_resp);
        int guard;
        beats = 0; req_cycles = 0; hold_bad = 0;
        guard = 0;
        while (!req_rdy_o && guard < 50) begin @(posedge clk); #1; guard++; end
        req_vld_i = 1; req_load_i = ld; req_store_i = st; req_size_i = sz;
        req_sign_i = sg; req_addr_i = ad; req_wdata_i = wd;
        @(posedge clk); #1;
        req_vld_i = 0; req_load_i = 0; req_store_i = 0;
        lat = 1;
        while (!rsp_vld_o && lat < 200) begin @(posedge clk); #1; lat++; end
        check("rsp_seen", rsp_vld_o, 1);
        r_data = rsp_data_o; r_err = rsp_err_o; rdy_in_resp = req_rdy_o;
        @(posedge clk); #1;
        check("rsp_single_pulse", rsp_vld_o, 0);
    endtask

    initial begin
        logic [DW-1:0] d, ed;
        logic          e, ee, rr;
        int            lat, eb, cnt, guard, kind;
        bit            ld, st, sg;
        logic [1:0]    sz;
        logic [AW-1:0] ad;
        logic [DW-1:0] wd;

        rst_i = 1; req_vld_i = 0; req_load_i = 0; req_store_i = 0; req_size_i = 0;
        req_sign_i = 0; req_addr_i = '0; req_wdata_i = '0;
        for (int i = 0; i < 1024; i++) begin
            bus_mem[i] = 8'($urandom);
            ref_mem[i] = bus_mem[i];
        end
        repeat (3) @(posedge clk);
        #1;
        check("reset_req_rdy", req_rdy_o, 1);
        check("reset_busy", busy_o, 0);
        check("reset_bus_req", bus_req_o, 0);
        check("reset_rsp_vld", rsp_vld_o, 0);
        check("reset_rsp_err", rsp_err_o, 0);
        check("reset_strb", bus_strb_o, 0);
        rst_i = 0;
        @(posedge clk); #1;

        // LW @0x100, zero-wait bus
        set_word(32'h100, 32'hDEADBEEF);
        model(1, 0, 2, 0, 32'h100, '0, ed, ee, eb);
        do_req(1, 0, 2, 0, 32'h100, '0, d, e, lat, rr);
        check("lw_data", d, 32'hDEADBEEF);
        check("lw_err", e, 0);
        check("lw_latency", lat, 3);
        check("lw_addr", b_addr[0], 32'h100);
        check("lw_strb", b_strb[0], 4'b1111);
        check("lw_we", b_we[0], 0);
        check("lw_rdy_in_resp", rr, 0);

        // LB / LBU @0x103
        set_word(32'h100, 32'h80123456);
        do_req(1, 0, 0, 1, 32'h103, '0, d, e, lat, rr);
        check("lb_strb", b_strb[0], 4'b1000);
        check("lb_data", d, 32'hFFFFFF80);
        do_req(1, 0, 0, 0, 32'h103, '0, d, e, lat, rr);
        check("lbu_data", d, 32'h00000080);

        // SH @0x102
        model(0, 1, 1, 0, 32'h102, 32'h0000ABCD, ed, ee, eb);
        do_req(0, 1, 1, 0, 32'h102, 32'h0000ABCD, d, e, lat, rr);
        check("sh_wdata", b_wdata[0], 32'hABCD0000);
        check("sh_strb", b_strb[0], 4'b1100);
        check("sh_we", b_we[0], 1);
        check("sh_rsp_data", d, 0);
        model(1, 0, 2, 0, 32'h100, '0, ed, ee, eb);
        do_req(1, 0, 2, 0, 32'h100, '0, d, e, lat, rr);
        check("sh_readback", d, ed);

        // Misaligned LW @0x101
        set_word(32'h100, 32'h33221100);
        set_word(32'h104, 32'h77665544);
        do_req(1, 0, 2, 0, 32'h101, '0, d, e, lat, rr);
`ifdef PA_CORE_LSU_MISALIGN_EN
        check("mis_data", d, 32'h44332211);
        check("mis_err", e, 0);
        check("mis_beats", beats, 2);
        check("mis_addr1", b_addr[0], 32'h100);
        check("mis_strb1", b_strb[0], 4'b1110);
        check("mis_addr2", b_addr[1], 32'h104);
        check("mis_strb2", b_strb[1], 4'b0001);
        check("mis_latency", lat, 5);
`else
        check("mis_err", e, 1);
        check("mis_no_bus", beats, 0);
        check("mis_data", d, 0);
        check("mis_latency", lat, 1);
`endif

        // Grant stalled three cycles
        gnt_delay = 3;
        do_req(1, 0, 2, 0, 32'h104, '0, d, e, lat, rr);
        gnt_delay = 0;
        check("stall_req_cycles", req_cycles, 4);
        check("stall_hold", hold_bad, 0);
        check("stall_data", d, 32'h77665544);
        check("stall_latency", lat, 6);

        // Split load with an error on the first beat
        model(1, 0, 2, 0, 32'h102, '0, ed, ee, eb);
        if (!ee) err_next = 1;
        do_req(1, 0, 2, 0, 32'h102, '0, d, e, lat, rr);
        err_next = 0;
        check("beat1_err_flag", e, 1);
        check("beat1_err_data", d, 0);
        check("beat1_err_beats", beats, (eb > 0) ? 1 : 0);

        // Reset while waiting for the first response
        rsp_delay = 3; beats = 0;
        req_vld_i = 1; req_load_i = 1; req_store_i = 0; req_size_i = 2; req_addr_i = 32'h100;
        @(posedge clk); #1;
        req_vld_i = 0; req_load_i = 0;
        guard = 0;
        while (beats == 0 && guard < 20) begin @(posedge clk); #1; guard++; end
        check("rst_grant_seen", beats, 1);
        @(posedge clk); #1;
        rst_i = 1;
        @(posedge clk); #1;
        rst_i = 0;
        check("rst_req_rdy", req_rdy_o, 1);
        check("rst_busy", busy_o, 0);
        check("rst_bus_req", bus_req_o, 0);
        check("rst_rsp_vld", rsp_vld_o, 0);
        cnt = 0;
        repeat (8) begin @(posedge clk); #1; if (rsp_vld_o) cnt++; end
        check("rst_late_rvld_ignored", cnt, 0);
        rsp_delay = 0;

        // Size 3 on a 32-bit bus, and malformed load/store flags
        do_req(1, 0, 3, 0, 32'h100, '0, d, e, lat, rr);
        check("size3_err", e, 1);
        check("size3_latency", lat, 1);
        check("size3_no_bus", beats, 0);
        do_req(1, 1, 2, 0, 32'h100, '0, d, e, lat, rr);
        check("both_err", e, 1);
        do_req(0, 0, 2, 0, 32'h100, '0, d, e, lat, rr);
        check("neither_err", e, 1);

        // Random traffic against the reference model
        for (int t = 0; t < 80; t++) begin
            kind = $urandom_range(0, 9);
            ld = (kind == 0) || (kind >= 6);
            st = (kind == 0) || (kind >= 2 && kind <= 5);
            sz = 2'($urandom_range(0, 3));
            sg = 1'($urandom);
            ad = 32'h200 + AW'($urandom_range(0, 63));
            wd = DW'($urandom);
            gnt_delay = $urandom_range(0, 2);
            rsp_delay = $urandom_range(0, 2);
            model(ld, st, sz, sg, ad, wd, ed, ee, eb);
            if (ld && !st && !ee && $urandom_range(0, 7) == 0) begin
                err_next = 1; ee = 1; ed = '0; eb = 1;
            end
            do_req(ld, st, sz, sg, ad, wd, d, e, lat, rr);
            err_next = 0;
            check("rand_err", e, ee);
            check("rand_data", d, ed);
            check("rand_beats", beats, eb);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pa_core_lsu.md
Name: pa_core_lsu

Overview:
- Sequential, parametrised load/store unit; successor to the single-cycle combinational memory access unit.
- Sits between the execute stage and the data bus master.
- Accepts one load/store request at a time over a valid/ready handshake and drives an aligned bus request/grant/response protocol with byte strobes.
- Aligns and sign/zero-extends load data, and returns a single response pulse; optionally splits misaligned accesses into two bus beats.

Parameters:
- DATA_WIDTH, 32, data bus width in bits; legal values 32 or 64. NB = DATA_WIDTH/8 bytes per beat.
- ADDR_WIDTH, 32, byte address width.

Ports:
- clk_i  input  1  core clock
- rst_i  input  1  synchronous active-high reset
- req_vld_i  input  1  request valid from execute stage
- req_rdy_o  output  1  unit ready to accept a request
- req_load_i  input  1  request is a load
- req_store_i  input  1  request is a store; load and store both high is illegal
- req_size_i  input  2  access size: 0 byte, 1 half, 2 word, 3 dword
- req_sign_i  input  1  load result sign-extended when 1, zero-extended when 0
- req_addr_i  input  ADDR_WIDTH  byte address
- req_wdata_i  input  DATA_WIDTH  store data, right-justified
- rsp_vld_o  output  1  one-cycle response pulse
- rsp_data_o  output  DATA_WIDTH  extended load data; 0 for stores
- rsp_err_o  output  1  bus error, illegal size, or misaligned access; valid with rsp_vld_o
- busy_o  output  1  unit not in IDLE
- bus_req_o  output  1  bus request
- bus_we_o  output  1  bus write enable
- bus_addr_o  output  ADDR_WIDTH  beat address, NB-aligned
- bus_wdata_o  output  DATA_WIDTH  lane-shifted store data
- bus_strb_o  output  NB  byte-lane strobes
- bus_gnt_i  input  1  bus accepted the request this cycle
- bus_rvld_i  input  1  beat response valid (read data or write ack)
- bus_rdata_i  input  DATA_WIDTH  read data
- bus_err_i  input  1  beat error, qualified by bus_rvld_i

Behaviour:
- Reset: all outputs are 0 except req_rdy_o = 1; state is IDLE.
- States: IDLE, REQ1, WAIT1, REQ2, WAIT2, RESP.
- IDLE:
  - req_rdy_o = 1.
  - Handshake on req_vld_i && req_rdy_o: latch the full request and compute off = addr mod NB and nbytes = 1 << size.
  - Illegal request goes directly to RESP with rsp_err_o = 1 and no bus activity. Illegal means size 3 with DATA_WIDTH=32, or load and store both high, or neither high.
  - Otherwise the next state is REQ1.
- REQ1:
  - bus_req_o = 1.
  - bus_addr_o = addr with the low log2(NB) bits cleared.
  - bus_strb_o = ((1<<nbytes)-1) << off, truncated to NB bits.
  - bus_wdata_o = wdata << (8*off).
  - bus_we_o = store.
  - All bus outputs are held stable until bus_gnt_i = 1, then the state moves to WAIT1.
- WAIT1:
  - bus_req_o = 0; wait for bus_rvld_i. bus_rvld_i is never earlier than the cycle after the grant.
  - Load: capture bus_rdata_i.
  - bus_err_i = 1 goes to RESP with the error flag set; the second beat is skipped.
  - Else, if the access is split (off + nbytes > NB), go to REQ2; otherwise go to RESP.
- REQ2/WAIT2:
  - Address = beat-1 address + NB.
  - Strobe = ((1<<nbytes)-1) >> (NB-off).
  - wdata = wdata >> (8*(NB-off)).
  - Same grant and response rules as beat 1; go to RESP after the response.
- RESP:
  - rsp_vld_o = 1 for exactly one cycle, then return to IDLE. req_rdy_o = 0 during RESP.
  - Minimum latency with zero-wait grant and response: handshake in cycle 0, bus_req_o in cycle 1, bus_rvld_i in cycle 2, rsp_vld_o in cycle 3.
  - Split access adds 2 cycles.
- Load merge:
  - raw = (beat1 >> 8*off) | (beat2 << 8*(NB-off)); beat2 = 0 when the access is not split.
  - Take the low 8*nbytes bits of raw and extend to DATA_WIDTH according to req_sign_i.
  - rsp_data_o is 0 on error and on stores.
- Bus response handling:
  - bus_rvld_i outside WAIT1/WAIT2 is ignored.
  - bus_gnt_i outside REQ1/REQ2 is ignored.
- Reset mid-operation:
  - Next cycle the unit is in IDLE with bus_req_o = 0 and rsp_vld_o = 0.
  - An in-flight bus response is discarded.

Optional Feature:
- Macro: PA_CORE_LSU_MISALIGN_EN.
- Defined: misaligned accesses are split into two beats as described above.
- Undefined:
  - Any access with off mod nbytes != 0 goes from IDLE directly to RESP with rsp_err_o = 1 and no bus request.
  - REQ2 and WAIT2 are not synthesised.

Test Plan:
- LW @0x100, zero-wait bus, rdata 0xDEADBEEF -> bus_addr_o 0x100, strb 4'b1111, we 0; rsp_vld_o in cycle 3 with rsp_data_o 0xDEADBEEF, err 0.
- LB sign=1 @0x103, rdata 0x80123456 -> strb 4'b1000, rsp 0xFFFFFF80; same access with LBU -> 0x00000080.
- SH @0x102, wdata 0x0000ABCD -> bus_wdata_o 0xABCD0000, strb 4'b1100, we 1; rsp_data_o 0.
- Misaligned LW @0x101, macro on: beat1 0x100 strb 4'b1110 rdata 0x33221100; beat2 0x104 strb 4'b0001 rdata 0x77665544 -> rsp 0x44332211. Macro off: rsp_err_o 1, bus_req_o never asserted.
- Grant stalled 3 cycles -> bus_req_o, bus_addr_o and bus_strb_o held constant. Split load with bus_err_i on beat1 -> rsp_err_o 1 and no second bus_req_o.
- rst_i asserted during WAIT1 -> next cycle req_rdy_o 1, busy_o 0, and a late bus_rvld_i produces no rsp_vld_o. Size 3 with DATA_WIDTH=32 -> rsp_err_o 1 in cycle 1.
